rot_rs_scheduler: RTL and testbench
===================================

Name: rot_rs_scheduler

Overview:
- Reservation station and issue scheduler in front of the 4-stage rotate/shift pipeline.
- Accepts dispatched rotate/shift/mask-insert operations whose operands may still be outstanding, and snoops the common result bus (CDB) for missing operands.
- Issues operand-complete entries to the pipeline over a valid/ready handshake and tags each issue with the entry's reservation-station id.

Parameters:
- RS_ID_WIDTH, 5: width of rs ids and operand tags.
- DEPTH, 4: number of entries, 2..16.
- BASE_ID, 8: rs id of entry 0; entry i issues as BASE_ID+i. BASE_ID+DEPTH-1 must fit in RS_ID_WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; invalidates all entries.
- disp_valid  input  1  dispatch request.
- disp_ready  output  1  at least one free entry.
- disp_result_reg_addr  input  5  destination GPR.
- disp_control  input  rotate_decode_t  decoded operation.
- disp_op1 / disp_op2 / disp_target / disp_xer  input  32 each  operand values.
- disp_op1_rdy / disp_op2_rdy / disp_target_rdy / disp_xer_rdy  input  1 each  value is final.
- disp_op1_tag / disp_op2_tag / disp_target_tag / disp_xer_tag  input  RS_ID_WIDTH each  producer id when not ready.
- cdb_valid  input  1  result broadcast valid.
- cdb_rs_id  input  RS_ID_WIDTH  producer id.
- cdb_result  input  32  GPR result.
- cdb_xer_valid  input  1  broadcast carries XER.
- cdb_xer  input  32  XER value.
- issue_valid  output  1  to pipeline input_valid.
- issue_ready  input  1  from pipeline input_ready.
- issue_rs_id  output  RS_ID_WIDTH  BASE_ID + selected index.
- issue_result_reg_addr  output  5.
- issue_op1 / issue_op2 / issue_target / issue_xer  output  32 each.
- issue_control  output  rotate_decode_t.

Behaviour:
- Entry contents: busy bit; per operand {rdy, tag, value} for op1, op2, target and xer; result_reg_addr; control.
- Reset (rst low, asynchronous): all busy bits and operand rdy bits clear and all stored fields zero. Outputs while reset is asserted: disp_ready=1, issue_valid=0, all issue data 0. Operations in flight are dropped.
- Dispatch:
  - disp_ready = any entry not busy, computed from current-cycle state only. An entry freed by issue in the same cycle is not reusable until the next cycle.
  - On disp_valid & disp_ready, the lowest-index free entry is written at the clock edge.
- CDB snoop:
  - Each cycle, every busy, not-ready op1/op2/target operand whose tag == cdb_rs_id captures cdb_result when cdb_valid=1.
  - A not-ready xer operand captures cdb_xer only when cdb_valid & cdb_xer_valid.
  - Bypass: a dispatching operand with rdy=0 whose tag matches the same-cycle CDB is stored as ready with the CDB value.
  - Operands already ready never change.
- Issue:
  - An entry is eligible when busy and all four operand rdy bits are set.
  - issue_valid = any eligible entry. The issue_* outputs are a combinational mux of the selected entry.
  - Selection: lowest eligible index. With ROT_RS_AGE_ORDER_EN, the oldest eligible entry is selected instead.
  - On issue_valid & issue_ready, the selected entry's busy bit clears at the edge.
  - The selection and issue_* outputs must stay stable while issue_valid=1 and issue_ready=0, unless flush is asserted. New entries becoming eligible must not displace a pending selection.
- Latency:
  - An entry dispatched with all operands ready can issue in the cycle after dispatch.
  - An entry woken by the CDB can issue in the cycle after the broadcast.
- Full / empty:
  - All DEPTH entries busy gives disp_ready=0.
  - Zero busy entries gives issue_valid=0.
- Simultaneous dispatch, CDB and issue are all legal in one cycle.
- flush: all entries are cleared at the edge. A dispatch in the same cycle is discarded. The issue handshake in that cycle still occurs; the pipeline discards it separately.

Optional Feature:
- Macro: ROT_RS_AGE_ORDER_EN.
- Defined: a DEPTH x DEPTH age matrix is maintained. On dispatch into entry i, row i is set to "older than i" for every busy entry. Selection picks the eligible entry with no older eligible entry.
- Not defined: fixed lowest-index priority and no age storage. Starvation freedom is not guaranteed.

Decomposition:
- ppc_types gets rot_rs_operand_t {rdy, tag, value} and rot_rs_entry_t.
- Sub-module rot_rs_operand_slot: one operand's storage, tag compare and CDB capture, instantiated 4 x DEPTH.

Test Plan:
- All-ready dispatch: dispatch op1=0x8000_0001, op2=1, control=rlwinm, all rdy, issue_ready=1 -> next cycle issue_valid=1, issue_rs_id=8, operands match; the following cycle issue_valid=0.
- Wakeup: dispatch with op2_rdy=0, tag=3; CDB rs_id=3, result=0x1F -> issue_valid=1 one cycle after the broadcast with issue_op2=0x1F. A CDB with rs_id=4 causes no wakeup.
- Same-cycle bypass: dispatch op1 tag=5, rdy=0, together with CDB rs_id=5, result=0xDEAD_BEEF -> issues next cycle with op1=0xDEADBEEF.
- Full and backpressure: fill 4 entries with issue_ready=0 -> disp_ready=0, and issue outputs are held stable for 10 cycles. Release issue_ready for 1 cycle -> disp_ready returns to 1 the following cycle.
- XER gating: xer tag=2 with cdb_valid=1, cdb_rs_id=2, cdb_xer_valid=0 -> no xer capture and no issue. Repeat with cdb_xer_valid=1 -> issue with captured xer.
- Reset / flush: assert rst low mid-cycle with 3 busy entries -> issue_valid drops immediately and disp_ready=1. flush with 2 entries -> both cleared next cycle. Under ROT_RS_AGE_ORDER_EN, entries 2 then 0 made eligible together -> entry 2 issues first.

Source files
------------

// File: rtl/rot_rs_scheduler_pkg.sv
// Shared types for the rotate/shift reservation station: decoded operation,
// operand and entry records, and operand slot numbering.
package rot_rs_scheduler_pkg;

  localparam int DATA_W   = 32;
  localparam int GPR_W    = 5;
  localparam int RS_TAG_W = 5;
  localparam int NUM_OPND = 4;

  typedef enum logic [1:0] {
    OPND_OP1 = 2'd0,
    OPND_OP2 = 2'd1,
    OPND_TGT = 2'd2,
    OPND_XER = 2'd3
  } opnd_sel_e;

  typedef enum logic [2:0] {
    ROT_RLWINM = 3'd0,
    ROT_RLWNM  = 3'd1,
    ROT_RLWIMI = 3'd2,
    ROT_SLW    = 3'd3,
    ROT_SRW    = 3'd4,
    ROT_SRAW   = 3'd5,
    ROT_SRAWI  = 3'd6
  } rot_op_e;

  typedef struct packed {
    rot_op_e    op;
    logic [4:0] sh;
    logic [4:0] mb;
    logic [4:0] me;
    logic       rc;
  } rotate_decode_t;

  typedef struct packed {
    logic                rdy;
    logic [RS_TAG_W-1:0] tag;
    logic [DATA_W-1:0]   value;
  } rot_rs_operand_t;

  typedef struct packed {
    logic                              busy;
    logic [GPR_W-1:0]                  result_reg_addr;
    rotate_decode_t                    control;
    rot_rs_operand_t [NUM_OPND-1:0]    opnd;
  } rot_rs_entry_t;

  // Per-entry fields that never change after dispatch.
  typedef struct packed {
    logic [GPR_W-1:0] result_reg_addr;
    rotate_decode_t   control;
  } rot_rs_meta_t;

endpackage

// File: rtl/rot_rs_operand_slot.sv
// One operand of one reservation-station entry: holds {rdy, tag, value},
// captures from the dispatch port (with same-cycle CDB bypass) or a later CDB hit.
module rot_rs_operand_slot
  import rot_rs_scheduler_pkg::*;
#(
  parameter int RS_ID_WIDTH = RS_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc,
  input  logic                   busy,
  input  logic                   disp_rdy,
  input  logic [RS_ID_WIDTH-1:0] disp_tag,
  input  logic [DATA_W-1:0]      disp_value,
  input  logic                   snoop_valid,
  input  logic [RS_ID_WIDTH-1:0] snoop_tag,
  input  logic [DATA_W-1:0]      snoop_value,
  output logic                   rdy,
  output logic [DATA_W-1:0]      value
);

  logic                   rdy_q, rdy_d;
  logic [RS_ID_WIDTH-1:0] tag_q, tag_d;
  logic [DATA_W-1:0]      value_q, value_d;
  logic                   bypass_hit, wake_hit;

  assign bypass_hit = snoop_valid && (disp_tag == snoop_tag);
  assign wake_hit   = busy && !rdy_q && snoop_valid && (tag_q == snoop_tag);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rdy_d   = rdy_q;
    tag_d   = tag_q;
    value_d = value_q;
    if (flush) begin
      rdy_d = 1'b0;
    end else if (alloc) begin
      tag_d = disp_tag;
      if (disp_rdy) begin
        rdy_d   = 1'b1;
        value_d = disp_value;
      end else if (bypass_hit) begin
        rdy_d   = 1'b1;
        value_d = snoop_value;
      end else begin
        rdy_d   = 1'b0;
        value_d = '0;
      end
    end else if (wake_hit) begin
      rdy_d   = 1'b1;
      value_d = snoop_value;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q   <= 1'b0;
      tag_q   <= '0;
      value_q <= '0;
    end else begin
      rdy_q   <= rdy_d;
      tag_q   <= tag_d;
      value_q <= value_d;
    end
  end

  assign rdy   = rdy_q;
  assign value = value_q;

endmodule

// File: rtl/rot_rs_scheduler.sv
// Reservation station / issue scheduler for the rotate/shift pipeline.
// Define ROT_RS_AGE_ORDER_EN for oldest-first issue; default is lowest index first.
module rot_rs_scheduler
  import rot_rs_scheduler_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int DEPTH       = 4,
  parameter int BASE_ID     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [4:0]             disp_result_reg_addr,
  input  rotate_decode_t         disp_control,
  input  logic [31:0]            disp_op1,
  input  logic [31:0]            disp_op2,
  input  logic [31:0]            disp_target,
  input  logic [31:0]            disp_xer,
  input  logic                   disp_op1_rdy,
  input  logic                   disp_op2_rdy,
  input  logic                   disp_target_rdy,
  input  logic                   disp_xer_rdy,
  input  logic [RS_ID_WIDTH-1:0] disp_op1_tag,
  input  logic [RS_ID_WIDTH-1:0] disp_op2_tag,
  input  logic [RS_ID_WIDTH-1:0] disp_target_tag,
  input  logic [RS_ID_WIDTH-1:0] disp_xer_tag,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  input  logic                   cdb_xer_valid,
  input  logic [31:0]            cdb_xer,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [4:0]             issue_result_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output logic [31:0]            issue_target,
  output logic [31:0]            issue_xer,
  output rotate_decode_t         issue_control
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0]      disp_val [NUM_OPND];
  logic [NUM_OPND-1:0]    disp_rdy;
  logic [RS_ID_WIDTH-1:0] disp_tag [NUM_OPND];

  assign disp_val[OPND_OP1] = disp_op1;
  assign disp_val[OPND_OP2] = disp_op2;
  assign disp_val[OPND_TGT] = disp_target;
  assign disp_val[OPND_XER] = disp_xer;
  assign disp_rdy = {disp_xer_rdy, disp_target_rdy, disp_op2_rdy, disp_op1_rdy};
  assign disp_tag[OPND_OP1] = disp_op1_tag;
  assign disp_tag[OPND_OP2] = disp_op2_tag;
  assign disp_tag[OPND_TGT] = disp_target_tag;
  assign disp_tag[OPND_XER] = disp_xer_tag;

  logic [DEPTH-1:0]    busy_q, busy_d;
  rot_rs_meta_t        meta_q [DEPTH];
  logic [NUM_OPND-1:0] opnd_rdy [DEPTH];
  logic [DATA_W-1:0]   opnd_val [DEPTH][NUM_OPND];
  logic [DEPTH-1:0]    eligible, cand, alloc_vec;
  logic [IDX_W-1:0]    alloc_idx, sel_idx, hold_idx_q, hold_idx_d;
  logic                hold_valid_q, hold_valid_d;
  logic                sel_found, disp_fire, issue_fire;

  assign disp_ready = ~&busy_q;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign issue_fire = issue_valid && issue_ready;

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    for (genvar k = 0; k < NUM_OPND; k++) begin : g_opnd
      localparam bit IS_XER = (k == int'(OPND_XER));
      rot_rs_operand_slot #(.RS_ID_WIDTH(RS_ID_WIDTH)) u_slot (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc       (alloc_vec[i]),
        .busy        (busy_q[i]),
        .disp_rdy    (disp_rdy[k]),
        .disp_tag    (disp_tag[k]),
        .disp_value  (disp_val[k]),
        .snoop_valid (IS_XER ? (cdb_valid && cdb_xer_valid) : cdb_valid),
        .snoop_tag   (cdb_rs_id),
        .snoop_value (IS_XER ? cdb_xer : cdb_result),
        .rdy         (opnd_rdy[i][k]),
        .value       (opnd_val[i][k])
      );
    end
    assign eligible[i]  = busy_q[i] && (&opnd_rdy[i]);
    assign alloc_vec[i] = disp_fire && (alloc_idx == IDX_W'(i));
  end

`ifdef ROT_RS_AGE_ORDER_EN
  // age_q[i][j] set means entry j was dispatched before entry i.
  logic [DEPTH-1:0] age_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) age_q[i][alloc_idx] <= 1'b0;
      age_q[alloc_idx] <= busy_q;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) cand[i] = eligible[i] && !(|(age_q[i] & eligible));
  end
`else
  assign cand = eligible;
`endif

  // NOTE: blocking assignment inside always_comb lets the loop see its own earlier result.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && cand[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    // A stalled offer stays put until it is taken or flushed.
    if (hold_valid_q) begin
      sel_found = 1'b1;
      sel_idx   = hold_idx_q;
    end
  end

  assign issue_valid = sel_found;

  always_comb begin
    busy_d       = busy_q;
    hold_valid_d = hold_valid_q;
    hold_idx_d   = hold_idx_q;
    if (issue_fire) busy_d[sel_idx] = 1'b0;
    if (disp_fire)  busy_d[alloc_idx] = 1'b1;
    if (flush) busy_d = '0;
    if (flush || issue_fire) begin
      hold_valid_d = 1'b0;
    end else if (issue_valid) begin
      hold_valid_d = 1'b1;
      hold_idx_d   = sel_idx;
    end
  end

  // NOTE: the entry metadata array is reset too, so outputs are defined from reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_idx_q   <= '0;
      for (int i = 0; i < DEPTH; i++) meta_q[i] <= '0;
    end else begin
      busy_q       <= busy_d;
      hold_valid_q <= hold_valid_d;
      hold_idx_q   <= hold_idx_d;
      if (disp_fire) begin
        meta_q[alloc_idx].result_reg_addr <= disp_result_reg_addr;
        meta_q[alloc_idx].control         <= disp_control;
      end
    end
  end

  always_comb begin
    issue_rs_id           = '0;
    issue_result_reg_addr = '0;
    issue_control         = '0;
    issue_op1             = '0;
    issue_op2             = '0;
    issue_target          = '0;
    issue_xer             = '0;
    if (issue_valid) begin
      issue_rs_id           = RS_ID_WIDTH'(BASE_ID) + RS_ID_WIDTH'(sel_idx);
      issue_result_reg_addr = meta_q[sel_idx].result_reg_addr;
      issue_control         = meta_q[sel_idx].control;
      issue_op1             = opnd_val[sel_idx][OPND_OP1];
      issue_op2             = opnd_val[sel_idx][OPND_OP2];
      issue_target          = opnd_val[sel_idx][OPND_TGT];
      issue_xer             = opnd_val[sel_idx][OPND_XER];
    end
  end

endmodule

// File: tb/tb_rot_rs_scheduler.sv
// Self-checking bench for rot_rs_scheduler: directed steps followed by random
// traffic, compared each cycle against an entry-level reference model.
module tb_rot_rs_scheduler;
  import rot_rs_scheduler_pkg::*;

  localparam int RS_ID_WIDTH = 5;
  localparam int DEPTH       = 4;
  localparam int BASE_ID     = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic disp_valid = 1'b0;
  logic disp_ready;
  logic [4:0] disp_result_reg_addr = '0;
  rotate_decode_t disp_control = '0;
  logic [31:0] d_val [4];
  logic        d_rdy [4];
  logic [4:0]  d_tag [4];
  logic cdb_valid = 1'b0;
  logic [RS_ID_WIDTH-1:0] cdb_rs_id = '0;
  logic [31:0] cdb_result = '0;
  logic cdb_xer_valid = 1'b0;
  logic [31:0] cdb_xer = '0;
  logic issue_valid;
  logic issue_ready = 1'b0;
  logic [RS_ID_WIDTH-1:0] issue_rs_id;
  logic [4:0] issue_result_reg_addr;
  logic [31:0] issue_op1, issue_op2, issue_target, issue_xer;
  rotate_decode_t issue_control;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  rot_rs_entry_t m_ent [DEPTH];
  int unsigned   m_seq [DEPTH];
  int unsigned   seq_ctr;
  bit            pend_v;
  int            pend_idx;

  always #5 clk = ~clk;

  rot_rs_scheduler #(.RS_ID_WIDTH(RS_ID_WIDTH), .DEPTH(DEPTH), .BASE_ID(BASE_ID)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .disp_valid            (disp_valid),
    .disp_ready            (disp_ready),
    .disp_result_reg_addr  (disp_result_reg_addr),
    .disp_control          (disp_control),
    .disp_op1              (d_val[0]),
    .disp_op2              (d_val[1]),
    .disp_target           (d_val[2]),
    .disp_xer              (d_val[3]),
    .disp_op1_rdy          (d_rdy[0]),
    .disp_op2_rdy          (d_rdy[1]),
    .disp_target_rdy       (d_rdy[2]),
    .disp_xer_rdy          (d_rdy[3]),
    .disp_op1_tag          (d_tag[0]),
    .disp_op2_tag          (d_tag[1]),
    .disp_target_tag       (d_tag[2]),
    .disp_xer_tag          (d_tag[3]),
    .cdb_valid             (cdb_valid),
    .cdb_rs_id             (cdb_rs_id),
    .cdb_result            (cdb_result),
    .cdb_xer_valid         (cdb_xer_valid),
    .cdb_xer               (cdb_xer),
    .issue_valid           (issue_valid),
    .issue_ready           (issue_ready),
    .issue_rs_id           (issue_rs_id),
    .issue_result_reg_addr (issue_result_reg_addr),
    .issue_op1             (issue_op1),
    .issue_op2             (issue_op2),
    .issue_target          (issue_target),
    .issue_xer             (issue_xer),
    .issue_control         (issue_control)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_ent[i] = '0;
      m_seq[i] = 0;
    end
    seq_ctr  = 0;
    pend_v   = 1'b0;
    pend_idx = 0;
  endtask

  function automatic bit m_eligible(input int i);
    bit all_rdy = 1'b1;
    for (int k = 0; k < 4; k++) if (!m_ent[i].opnd[k].rdy) all_rdy = 1'b0;
    return m_ent[i].busy && all_rdy;
  endfunction

  // Pending offer first; otherwise lowest index, or oldest when age ordering is built in.
  function automatic int model_sel();
    int best = -1;
    if (pend_v) return pend_idx;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_eligible(i)) begin
`ifdef ROT_RS_AGE_ORDER_EN
        if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic bit cdb_hits(input int k, input logic [4:0] tag);
    return cdb_valid && (tag == cdb_rs_id) && (k != 3 || cdb_xer_valid);
  endfunction

  task automatic check_outputs();
    int s = model_sel();
    bit free = 1'b0;
    rot_rs_entry_t e = '0;
    logic [31:0] exp_id = '0;
    for (int i = 0; i < DEPTH; i++) if (!m_ent[i].busy) free = 1'b1;
    if (s >= 0) begin
      e = m_ent[s];
      exp_id = 32'(BASE_ID + s);
    end
    check("disp_ready", 32'(disp_ready), 32'(free));
    check("issue_valid", 32'(issue_valid), 32'(s >= 0));
    check("issue_rs_id", 32'(issue_rs_id), exp_id);
    check("issue_rra", 32'(issue_result_reg_addr), 32'(e.result_reg_addr));
    check("issue_control", 32'(issue_control), 32'(e.control));
    check("issue_op1", issue_op1, e.opnd[0].value);
    check("issue_op2", issue_op2, e.opnd[1].value);
    check("issue_target", issue_target, e.opnd[2].value);
    check("issue_xer", issue_xer, e.opnd[3].value);
  endtask

  task automatic model_update();
    int  s = model_sel();
    bit  fire = (s >= 0) && issue_ready;
    int  fidx = -1;
    for (int i = 0; i < DEPTH; i++) if (!m_ent[i].busy && fidx < 0) fidx = i;
    for (int i = 0; i < DEPTH; i++)
      for (int k = 0; k < 4; k++)
        if (m_ent[i].busy && !m_ent[i].opnd[k].rdy && cdb_hits(k, m_ent[i].opnd[k].tag)) begin
          m_ent[i].opnd[k].rdy   = 1'b1;
          m_ent[i].opnd[k].value = (k == 3) ? cdb_xer : cdb_result;
        end
    if (fire) m_ent[s].busy = 1'b0;
    if (disp_valid && fidx >= 0 && !flush) begin
      m_ent[fidx].busy            = 1'b1;
      m_ent[fidx].result_reg_addr = disp_result_reg_addr;
      m_ent[fidx].control         = disp_control;
      for (int k = 0; k < 4; k++) begin
        m_ent[fidx].opnd[k].tag = d_tag[k];
        if (d_rdy[k]) begin
          m_ent[fidx].opnd[k].rdy   = 1'b1;
          m_ent[fidx].opnd[k].value = d_val[k];
        end else if (cdb_hits(k, d_tag[k])) begin
          m_ent[fidx].opnd[k].rdy   = 1'b1;
          m_ent[fidx].opnd[k].value = (k == 3) ? cdb_xer : cdb_result;
        end else begin
          m_ent[fidx].opnd[k].rdy   = 1'b0;
          m_ent[fidx].opnd[k].value = '0;
        end
      end
      m_seq[fidx] = seq_ctr;
      seq_ctr++;
    end
    if (flush || fire) pend_v = 1'b0;
    else if (s >= 0) begin
      pend_v   = 1'b1;
      pend_idx = s;
    end
    if (flush) for (int i = 0; i < DEPTH; i++) m_ent[i].busy = 1'b0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    check_outputs();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3);
    d_val[0] = v0; d_val[1] = v1; d_val[2] = v2; d_val[3] = v3;
    for (int k = 0; k < 4; k++) begin
      d_rdy[k] = 1'b1;
      d_tag[k] = '0;
    end
  endtask

  task automatic cdb_off();
    cdb_valid = 1'b0;
    cdb_xer_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rotate_decode_t rlwinm;
    rlwinm = '{op: ROT_RLWINM, sh: 5'd1, mb: 5'd0, me: 5'd31, rc: 1'b0};
    for (int k = 0; k < 4; k++) begin
      d_val[k] = '0;
      d_rdy[k] = 1'b0;
      d_tag[k] = '0;
    end
    model_reset();

    // Reset state.
    #3;
    check("rst_disp_ready", 32'(disp_ready), 32'd1);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_op1", issue_op1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // All-ready dispatch issues the next cycle.
    issue_ready = 1'b1;
    disp_valid = 1'b1;
    disp_control = rlwinm;
    disp_result_reg_addr = 5'd3;
    set_ops(32'h8000_0001, 32'h1, 32'h0, 32'h0);
    step();
    disp_valid = 1'b0;
    check("t1_valid", 32'(issue_valid), 32'd1);
    check("t1_rs_id", 32'(issue_rs_id), 32'd8);
    check("t1_op1", issue_op1, 32'h8000_0001);
    step();
    check("t1_drained", 32'(issue_valid), 32'd0);

    // CDB wakeup, including a non-matching broadcast.
    disp_valid = 1'b1;
    set_ops(32'h10, 32'h0, 32'h0, 32'h0);
    d_rdy[1] = 1'b0; d_tag[1] = 5'd3;
    step();
    disp_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rs_id = 5'd4; cdb_result = 32'h55;
    step();
    check("t2_no_wake", 32'(issue_valid), 32'd0);
    cdb_rs_id = 5'd3; cdb_result = 32'h1F;
    step();
    cdb_off();
    check("t2_wake_valid", 32'(issue_valid), 32'd1);
    check("t2_wake_op2", issue_op2, 32'h1F);
    step();

    // Same-cycle bypass.
    disp_valid = 1'b1;
    set_ops(32'h0, 32'h2, 32'h0, 32'h0);
    d_rdy[0] = 1'b0; d_tag[0] = 5'd5;
    cdb_valid = 1'b1; cdb_rs_id = 5'd5; cdb_result = 32'hDEAD_BEEF;
    step();
    disp_valid = 1'b0;
    cdb_off();
    check("t3_bypass_op1", issue_op1, 32'hDEAD_BEEF);
    step();

    // Fill under backpressure, hold stable, then release one.
    issue_ready = 1'b0;
    disp_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      set_ops(32'h100 + 32'(n), 32'h0, 32'h0, 32'h0);
      step();
    end
    disp_valid = 1'b0;
    check("t4_full", 32'(disp_ready), 32'd0);
    for (int n = 0; n < 10; n++) begin
      step();
      check("t4_hold_id", 32'(issue_rs_id), 32'd8);
      check("t4_hold_op1", issue_op1, 32'h100);
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    check("t4_ready_back", 32'(disp_ready), 32'd1);
    check("t4_next_id", 32'(issue_rs_id), 32'd9);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_flush_valid", 32'(issue_valid), 32'd0);
    check("t5_flush_ready", 32'(disp_ready), 32'd1);

    // XER capture needs cdb_xer_valid.
    issue_ready = 1'b1;
    disp_valid = 1'b1;
    set_ops(32'h7, 32'h8, 32'h9, 32'h0);
    d_rdy[3] = 1'b0; d_tag[3] = 5'd2;
    step();
    disp_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rs_id = 5'd2; cdb_result = 32'h1234; cdb_xer = 32'hAAAA_0000;
    step();
    check("t6_no_xer", 32'(issue_valid), 32'd0);
    cdb_xer_valid = 1'b1; cdb_xer = 32'h2000_0000;
    step();
    cdb_off();
    check("t6_xer_valid", 32'(issue_valid), 32'd1);
    check("t6_xer_val", issue_xer, 32'h2000_0000);
    step();

    // Entry 2 made older than entry 0, both woken together.
    issue_ready = 1'b0;
    disp_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      set_ops(32'h0, 32'h30 + 32'(n), 32'h0, 32'h0);
      d_rdy[0] = 1'b0; d_tag[0] = (n == 2) ? 5'd7 : 5'd6;
      step();
    end
    disp_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rs_id = 5'd6; cdb_result = 32'h66;
    issue_ready = 1'b1;
    step();
    cdb_off();
    step();
    step();
    check("t7_idle", 32'(issue_valid), 32'd0);
    issue_ready = 1'b0;
    disp_valid = 1'b1;
    set_ops(32'h0, 32'h40, 32'h0, 32'h0);
    d_rdy[0] = 1'b0; d_tag[0] = 5'd7;
    step();
    disp_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rs_id = 5'd7; cdb_result = 32'h77;
    step();
    cdb_off();
`ifdef ROT_RS_AGE_ORDER_EN
    check("t7_first_id", 32'(issue_rs_id), 32'd10);
`else
    check("t7_first_id", 32'(issue_rs_id), 32'd8);
`endif
    issue_ready = 1'b1;
    step();
    step();
    step();

    // Asynchronous reset mid-cycle with three busy entries.
    issue_ready = 1'b0;
    disp_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      set_ops(32'h200 + 32'(n), 32'h0, 32'h0, 32'h0);
      step();
    end
    disp_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t8_rst_valid", 32'(issue_valid), 32'd0);
    check("t8_rst_ready", 32'(disp_ready), 32'd1);
    check("t8_rst_op1", issue_op1, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      disp_valid = ($urandom_range(0, 1) == 1);
      disp_result_reg_addr = 5'($urandom);
      disp_control = '{op: rot_op_e'($urandom_range(0, 6)), sh: 5'($urandom),
                       mb: 5'($urandom), me: 5'($urandom), rc: 1'($urandom)};
      for (int k = 0; k < 4; k++) begin
        d_val[k] = $urandom;
        d_rdy[k] = ($urandom_range(0, 9) < 6);
        d_tag[k] = 5'($urandom_range(6, 11));
      end
      cdb_valid     = ($urandom_range(0, 1) == 1);
      cdb_rs_id     = 5'($urandom_range(6, 11));
      cdb_result    = $urandom;
      cdb_xer_valid = ($urandom_range(0, 1) == 1);
      cdb_xer       = $urandom;
      issue_ready   = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 39) == 0);
      step();
    end
    disp_valid = 1'b0;
    cdb_off();
    flush = 1'b0;
    issue_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
